// File: rtl/crossbar_route_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossbars_seq_pkg
// Brief    : Sequencer state encoding and route word pack/unpack helpers.
// Revision : 1.0 - initial release
// ============================================================================
package crossbars_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_RUN   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FIN   = 3'd5
    } seq_state_e;

    // Route word layout: input_sel occupies the MSBs, output_sel sits directly below.
    function automatic int unsigned route_input_sel(input int unsigned route,
                                                    input int unsigned n_outputs);
        return route / n_outputs;
    endfunction

    function automatic int unsigned route_output_sel(input int unsigned route,
                                                     input int unsigned n_outputs);
        return route % n_outputs;
    endfunction

    function automatic int unsigned route_pack(input int unsigned in_sel,
                                               input int unsigned out_sel,
                                               input int unsigned n_outputs);
        return (in_sel * n_outputs) + out_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crossbar_route_sequencer_table.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_route_table
// Brief    : Route/count register file, synchronous write, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module crossbar_route_table #(
    parameter int N_ENTRIES   = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int ROUTE_WIDTH = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [ROUTE_WIDTH-1:0] wr_route,
    input  logic [COUNT_WIDTH-1:0] wr_count,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [ROUTE_WIDTH-1:0] rd_route,
    output logic [COUNT_WIDTH-1:0] rd_count
);

    localparam int ENTRY_WIDTH = ROUTE_WIDTH + COUNT_WIDTH;

    logic [ENTRY_WIDTH-1:0] mem_q [N_ENTRIES];
    logic [ENTRY_WIDTH-1:0] mem_d [N_ENTRIES];
    logic [N_ENTRIES-1:0]   valid_q;
    logic [N_ENTRIES-1:0]   valid_d;
    logic [ENTRY_WIDTH-1:0] w_entry;

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (wr_en) begin
            mem_d[wr_addr]   = {wr_route, wr_count};
            valid_d[wr_addr] = 1'b1;
        end
    end

    // Data storage is never reset; only the valid flags are, so unwritten
    // entries present as a zero-count skip.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign w_entry  = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
    assign rd_route = w_entry[ENTRY_WIDTH-1:COUNT_WIDTH];
    assign rd_count = w_entry[COUNT_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/crossbar_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_route_sequencer
// Brief    : Steps a programmable route table onto the crossbar control port,
//            counting routed-output transfers per entry. Optional continuous
//            looping is enabled by defining CROSSBAR_SEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module crossbar_route_sequencer
    import crossbars_seq_pkg::*;
#(
    parameter  int N_INPUTS          = 2,
    parameter  int N_OUTPUTS         = 2,
    parameter  int N_ENTRIES         = 8,
    parameter  int COUNT_WIDTH       = 16,
    localparam int CONTROL_BIT_WIDTH = $clog2(N_INPUTS * N_OUTPUTS),
    localparam int ADDR_WIDTH        = $clog2(N_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0]        cfg_wr_addr,
    input  logic [CONTROL_BIT_WIDTH-1:0] cfg_wr_route,
    input  logic [COUNT_WIDTH-1:0]       cfg_wr_count,
    input  logic [ADDR_WIDTH:0]          cfg_len,
    input  logic                         start,
    input  logic                         stop,
`ifdef CROSSBAR_SEQ_LOOP_EN
    input  logic                         loop_en,
`endif
    output logic [CONTROL_BIT_WIDTH-1:0] control,
    output logic                         control_val,
    input  logic                         control_rdy,
    input  logic                         mon_val [N_OUTPUTS],
    input  logic                         mon_rdy [N_OUTPUTS],
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        cur_index
);

    localparam int OSEL_WIDTH = $clog2(N_OUTPUTS);

    seq_state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        index_q, index_d;
    logic [ADDR_WIDTH:0]          len_q, len_d;
    logic [COUNT_WIDTH-1:0]       remaining_q, remaining_d;
    logic [CONTROL_BIT_WIDTH-1:0] control_q, control_d;

    logic [CONTROL_BIT_WIDTH-1:0] w_entry_route;
    logic [COUNT_WIDTH-1:0]       w_entry_count;
    logic [OSEL_WIDTH-1:0]        w_out_sel;
    logic [ADDR_WIDTH:0]          w_index_inc;
    logic                         w_fire;
    logic                         w_last;
    logic                         w_loop;
    logic                         w_tbl_wr_en;

    assign w_tbl_wr_en = cfg_wr_en && (state_q == ST_IDLE) && !reset;

    crossbar_route_table #(
        .N_ENTRIES   (N_ENTRIES),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ROUTE_WIDTH (CONTROL_BIT_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_tbl_wr_en),
        .wr_addr  (cfg_wr_addr),
        .wr_route (cfg_wr_route),
        .wr_count (cfg_wr_count),
        .rd_addr  (index_q),
        .rd_route (w_entry_route),
        .rd_count (w_entry_count)
    );

    // Only the output this route targets is monitored; other outputs may fire freely.
    assign w_out_sel   = OSEL_WIDTH'(route_output_sel(32'(control_q), N_OUTPUTS));
    assign w_fire      = mon_val[w_out_sel] && mon_rdy[w_out_sel];
    assign w_index_inc = {1'b0, index_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_last      = (w_index_inc == len_q);

`ifdef CROSSBAR_SEQ_LOOP_EN
    assign w_loop = loop_en;
`else
    assign w_loop = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        control_d   = control_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    index_d = '0;
                    state_d = (cfg_len == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_entry_count == '0) begin
                    state_d = ST_NEXT;
                end else begin
                    remaining_d = w_entry_count;
                    control_d   = w_entry_route;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (control_rdy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fire && (remaining_q != '0)) begin
                    remaining_d = remaining_q - COUNT_WIDTH'(1);
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (w_last) begin
                    if (w_loop) begin
                        index_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    index_d = index_q + ADDR_WIDTH'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            control_q   <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            control_q   <= control_d;
        end
    end

    // The route register is left untouched on completion so the crossbar keeps the last path.
    assign control     = control_q;
    assign control_val = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign cur_index   = index_q;

endmodule
`default_nettype wire

// File: tb/tb_crossbar_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossbar_route_sequencer
// Brief    : Directed self-checking bench for crossbar_route_sequencer (2x2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossbar_route_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr_en;
    logic [2:0]  cfg_wr_addr;
    logic [1:0]  cfg_wr_route;
    logic [15:0] cfg_wr_count;
    logic [3:0]  cfg_len;
    logic        start;
    logic        stop;
`ifdef CROSSBAR_SEQ_LOOP_EN
    logic        loop_en;
`endif
    logic [1:0]  control;
    logic        control_val;
    logic        control_rdy;
    logic        mon_val [2];
    logic        mon_rdy [2];
    logic        busy;
    logic        done;
    logic [2:0]  cur_index;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crossbar_route_sequencer #(
        .N_INPUTS    (2),
        .N_OUTPUTS   (2),
        .N_ENTRIES   (8),
        .COUNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_route (cfg_wr_route),
        .cfg_wr_count (cfg_wr_count),
        .cfg_len      (cfg_len),
        .start        (start),
        .stop         (stop),
`ifdef CROSSBAR_SEQ_LOOP_EN
        .loop_en      (loop_en),
`endif
        .control      (control),
        .control_val  (control_val),
        .control_rdy  (control_rdy),
        .mon_val      (mon_val),
        .mon_rdy      (mon_rdy),
        .busy         (busy),
        .done         (done),
        .cur_index    (cur_index)
    );

    // Inputs change and outputs are observed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_mon(input logic f0, input logic f1);
        mon_val[0] = f0; mon_rdy[0] = f0;
        mon_val[1] = f1; mon_rdy[1] = f1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [1:0] r, input logic [15:0] c);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_route = r; cfg_wr_count = c;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] len);
        cfg_len = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (control_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", control_val); end
        checks++; if (control !== 2'b00) begin errors++; $display("FAIL reset_control: got %b expected 00", control); end
        checks++; if (cur_index !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", cur_index); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got %b expected 0", busy); end
    endtask

    task automatic test_single_route();
        write_entry(3'd0, 2'b10, 16'd3);
        pulse_start(4'd1);
        checks++; if ({busy, control_val} !== 2'b10) begin errors++; $display("FAIL single_load: got busy,val=%b expected 10", {busy, control_val}); end
        tick();
        checks++; if ({control_val, control} !== 3'b110) begin errors++; $display("FAIL single_issue: got val,ctl=%b expected 110", {control_val, control}); end
        tick();
        checks++; if (control_val !== 1'b0) begin errors++; $display("FAIL single_run_val: got %b expected 0", control_val); end
        set_mon(1'b1, 1'b0);
        tick(); tick();
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL single_after2: got busy,done=%b expected 10", {busy, done}); end
        tick();
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL single_next: got busy,done=%b expected 10", {busy, done}); end
        set_mon(1'b0, 1'b0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done); end
        tick();
        checks++; if ({busy, done, control} !== 4'b0010) begin errors++; $display("FAIL single_idle: got busy,done,ctl=%b expected 0010", {busy, done, control}); end
    endtask

    task automatic test_backpressure();
        write_entry(3'd0, 2'b10, 16'd2);
        control_rdy = 1'b0;
        pulse_start(4'd1);
        tick();
        set_mon(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({control_val, control} !== 3'b110) begin errors++; $display("FAIL bp_hold%0d: got val,ctl=%b expected 110", i, {control_val, control}); end
            tick();
        end
        control_rdy = 1'b1;
        checks++; if (control_val !== 1'b1) begin errors++; $display("FAIL bp_handshake: got %b expected 1", control_val); end
        tick();
        checks++; if ({busy, control_val} !== 2'b10) begin errors++; $display("FAIL bp_run: got busy,val=%b expected 10", {busy, control_val}); end
        tick();
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL bp_run2: got busy,done=%b expected 10", {busy, done}); end
        tick();
        set_mon(1'b0, 1'b0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done); end
        tick();
    endtask

    task automatic test_wrong_output();
        write_entry(3'd0, 2'b01, 16'd2);
        pulse_start(4'd1);
        tick();
        checks++; if ({control_val, control} !== 3'b101) begin errors++; $display("FAIL filt_issue: got val,ctl=%b expected 101", {control_val, control}); end
        tick();
        set_mon(1'b1, 1'b0);
        repeat (5) tick();
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL filt_ignore: got busy,done=%b expected 10", {busy, done}); end
        set_mon(1'b0, 1'b1);
        tick();
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL filt_one: got busy,done=%b expected 10", {busy, done}); end
        tick();
        set_mon(1'b0, 1'b0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL filt_done: got %b expected 1", done); end
        tick();
    endtask

    task automatic test_skip();
        write_entry(3'd0, 2'b00, 16'd1);
        write_entry(3'd1, 2'b11, 16'd0);
        write_entry(3'd2, 2'b11, 16'd1);
        pulse_start(4'd3);
        tick();
        checks++; if ({control_val, control} !== 3'b100) begin errors++; $display("FAIL skip_issue0: got val,ctl=%b expected 100", {control_val, control}); end
        tick();
        set_mon(1'b1, 1'b0);
        tick();
        set_mon(1'b0, 1'b0);
        tick();
        checks++; if ({control_val, cur_index} !== 4'b0001) begin errors++; $display("FAIL skip_load1: got val,idx=%b expected 0001", {control_val, cur_index}); end
        tick();
        checks++; if ({control_val, cur_index} !== 4'b0001) begin errors++; $display("FAIL skip_next1: got val,idx=%b expected 0001", {control_val, cur_index}); end
        tick();
        checks++; if (cur_index !== 3'd2) begin errors++; $display("FAIL skip_load2: got %0d expected 2", cur_index); end
        tick();
        checks++; if ({control_val, control} !== 3'b111) begin errors++; $display("FAIL skip_issue2: got val,ctl=%b expected 111", {control_val, control}); end
        tick();
        set_mon(1'b0, 1'b1);
        tick();
        set_mon(1'b0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL skip_next2: got %b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL skip_done: got %b expected 1", done); end
        tick();
    endtask

    task automatic test_zero_len();
        cfg_len = 4'd0; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if ({busy, done, control_val} !== 3'b110) begin errors++; $display("FAIL zlen_fin: got busy,done,val=%b expected 110", {busy, done, control_val}); end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zlen_idle: got busy,done=%b expected 00", {busy, done}); end
    endtask

    task automatic test_abort();
        write_entry(3'd0, 2'b10, 16'd1);
        write_entry(3'd1, 2'b10, 16'd6);
        pulse_start(4'd2);
        tick(); tick();
        set_mon(1'b1, 1'b0);
        tick();
        set_mon(1'b0, 1'b0);
        tick();
        checks++; if (cur_index !== 3'd1) begin errors++; $display("FAIL abort_load1: got %0d expected 1", cur_index); end
        tick(); tick();
        set_mon(1'b1, 1'b0);
        tick();
        set_mon(1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if ({busy, done, control_val} !== 3'b000) begin errors++; $display("FAIL abort_idle: got busy,done,val=%b expected 000", {busy, done, control_val}); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone: got %b expected 0", done); end
        pulse_start(4'd2);
        checks++; if ({busy, cur_index} !== 4'b1000) begin errors++; $display("FAIL abort_restart: got busy,idx=%b expected 1000", {busy, cur_index}); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stop2: got %b expected 0", busy); end
    endtask

    task automatic test_lockout_and_reset();
        write_entry(3'd0, 2'b10, 16'd1);
        pulse_start(4'd1);
        cfg_wr_en = 1'b1; cfg_wr_addr = 3'd0; cfg_wr_route = 2'b01; cfg_wr_count = 16'd9;
        tick();
        cfg_wr_en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        pulse_start(4'd1);
        tick();
        checks++; if ({control_val, control} !== 3'b110) begin errors++; $display("FAIL lock_route: got val,ctl=%b expected 110", {control_val, control}); end
        tick();
        set_mon(1'b1, 1'b0);
        tick();
        set_mon(1'b0, 1'b0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lock_count: got %b expected 1", done); end
        tick();
        control_rdy = 1'b0;
        pulse_start(4'd1);
        tick();
        checks++; if (control_val !== 1'b1) begin errors++; $display("FAIL rst_issue: got %b expected 1", control_val); end
        reset = 1'b1;
        tick();
        checks++; if ({control_val, busy, control} !== 4'b0000) begin errors++; $display("FAIL rst_mid_issue: got val,busy,ctl=%b expected 0000", {control_val, busy, control}); end
        reset = 1'b0;
        control_rdy = 1'b1;
        tick();
    endtask

`ifdef CROSSBAR_SEQ_LOOP_EN
    task automatic test_loop();
        logic [1:0] exp_route;
        loop_en = 1'b1;
        write_entry(3'd0, 2'b10, 16'd1);
        write_entry(3'd1, 2'b11, 16'd1);
        set_mon(1'b1, 1'b1);
        pulse_start(4'd2);
        for (int k = 0; k < 4; k++) begin
            exp_route = (k % 2 == 0) ? 2'b10 : 2'b11;
            tick();
            checks++; if ({control_val, control} !== {1'b1, exp_route}) begin errors++; $display("FAIL loop_issue%0d: got val,ctl=%b expected %b", k, {control_val, control}, {1'b1, exp_route}); end
            tick(); tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_nodone%0d: got %b expected 0", k, done); end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        set_mon(1'b0, 1'b0);
        loop_en = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL loop_stop: got busy,done=%b expected 00", {busy, done}); end
    endtask
`endif

    initial begin
        reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_route = '0; cfg_wr_count = '0;
        cfg_len = '0; start = 1'b0; stop = 1'b0; control_rdy = 1'b1;
`ifdef CROSSBAR_SEQ_LOOP_EN
        loop_en = 1'b0;
`endif
        set_mon(1'b0, 1'b0);
        test_reset();
        test_single_route();
        test_backpressure();
        test_wrong_output();
        test_skip();
        test_zero_len();
        test_abort();
        test_lockout_and_reset();
`ifdef CROSSBAR_SEQ_LOOP_EN
        test_loop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
